// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, the instruction width, the PC step and the default boot address.
package ifu_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          INST_W           = 32;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register with an async reset to the boot address.
// A redirect load takes priority over the sequential +4 increment.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = load_pc;
    end else if (inc) begin
      pc_next = pc + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one instruction memory request outstanding,
// hands fetched words to decode and applies redirects from execute.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] Instruction_Code,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fault,
  output logic [31:0]       fetch_count,
  output fetch_state_e      state_dbg
);

  // Decode handshake: a word moves when inst_valid & inst_ready on a rising edge;
  // while inst_valid is high and inst_ready low, Instruction_Code/inst_pc do not change.

  fetch_state_e    state, state_d;
  logic            redirect_ok, redirect_bad, transfer;
  logic            pc_load, pc_inc, capture;
  logic [XLEN-1:0] pc, pc_next;

  assign transfer     = inst_valid & inst_ready;
  assign redirect_ok  = redirect_valid & is_aligned(redirect_pc[1:0]);
  assign redirect_bad = redirect_valid & ~is_aligned(redirect_pc[1:0]);
  assign state_dbg    = state;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock   (clock),
    .reset   (reset),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (redirect_pc),
    .pc      (pc),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d = state;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    case (state)
      BOOT: begin
        state_d = redirect_bad ? HALT : FETCH;
        pc_load = redirect_ok;
      end
      FETCH: begin
        if (redirect_bad) begin
          state_d = HALT;
        end else if (redirect_ok) begin
          // An unacked request must still complete before the new target is fetched.
          pc_load = 1'b1;
          state_d = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          pc_inc  = 1'b1;
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_bad) begin
          state_d = HALT;
        end else if (redirect_ok) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (transfer) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_bad) begin
          state_d = HALT;
        end else begin
          pc_load = redirect_ok;
          if (imem_ack) state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= BOOT;
      imem_req         <= 1'b0;
      imem_addr        <= RESET_PC;
      inst_valid       <= 1'b0;
      Instruction_Code <= '0;
      inst_pc          <= '0;
      fault            <= 1'b0;
      fetch_count      <= '0;
    end else begin
      state      <= state_d;
      imem_req   <= (state_d == FETCH) || (state_d == DRAIN);
      inst_valid <= (state_d == HOLD);
      // DRAIN keeps presenting the old address until its ack arrives.
      if (state_d == FETCH) imem_addr <= pc_next;
      if (capture) begin
        Instruction_Code <= imem_rdata;
        inst_pc          <= pc;
      end
      if (state_d == HALT) fault <= 1'b1;
      if (transfer) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the fetch unit (outstanding request, discard flag, delivered word).
module tb_ifu_fetch_ctrl;
  import ifu_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic         clock = 1'b0;
  logic         reset;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  Instruction_Code;
  logic [31:0]  inst_pc;
  logic         fault;
  logic [31:0]  fetch_count;
  fetch_state_e state_dbg;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clock            (clock),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .Instruction_Code (Instruction_Code),
    .inst_pc          (inst_pc),
    .fault            (fault),
    .fetch_count      (fetch_count),
    .state_dbg        (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] code;
    logic [31:0] ipc;
    logic [31:0] count;
    logic        req;
    logic        valid;
    logic        fault;
    logic        boot;
    logic        discard;
    logic        halt;
  } model_t;

  model_t      m;
  logic [31:0] exp_q[$];

  function automatic model_t model_reset();
    model_t r;
    r.pc = RPC; r.addr = RPC; r.code = '0; r.ipc = '0; r.count = '0;
    r.req = 1'b0; r.valid = 1'b0; r.fault = 1'b0; r.boot = 1'b1;
    r.discard = 1'b0; r.halt = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t s, input logic rv, input logic [31:0] rpc,
                                        input logic ack_in, input logic [31:0] rdata,
                                        input logic ready);
    model_t n = s;
    logic ack  = s.req & ack_in;
    logic xfer = s.valid & ready;
    if (s.halt) return n;
    if (xfer) n.count = s.count + 32'd1;
    if (rv) begin
      n.boot = 1'b0;
      if (rpc[1:0] != 2'b00) begin
        n.halt = 1'b1; n.fault = 1'b1; n.req = 1'b0; n.valid = 1'b0;
      end else begin
        n.pc    = rpc;
        n.valid = 1'b0;
        if (s.req && !ack) begin
          n.discard = 1'b1;
        end else begin
          n.req = 1'b1; n.addr = rpc; n.discard = 1'b0;
        end
      end
    end else if (s.boot) begin
      n.boot = 1'b0; n.req = 1'b1; n.addr = s.pc;
    end else if (ack) begin
      if (s.discard) begin
        n.discard = 1'b0; n.addr = s.pc;
      end else begin
        n.code = rdata; n.ipc = s.addr; n.valid = 1'b1; n.req = 1'b0; n.pc = s.pc + 32'd4;
      end
    end else if (xfer) begin
      n.valid = 1'b0; n.req = 1'b1; n.addr = s.pc;
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m <= model_reset();
    end else begin
      if (!m.halt && m.valid && inst_ready) exp_q.push_back(m.ipc);
      m <= model_next(m, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    check("imem_req",         {31'd0, imem_req},   {31'd0, m.req});
    check("imem_addr",        imem_addr,           m.addr);
    check("inst_valid",       {31'd0, inst_valid}, {31'd0, m.valid});
    check("fault",            {31'd0, fault},      {31'd0, m.fault});
    check("fetch_count",      fetch_count,         m.count);
    if (m.valid) begin
      check("Instruction_Code", Instruction_Code, m.code);
      check("inst_pc",          inst_pc,          m.ipc);
    end
  end

  // ---------------- driver tasks ----------------
  int          mem_lat     = 0;
  int          mem_cnt     = 0;
  logic [31:0] mem_word    = '0;
  logic        rand_data   = 1'b0;
  logic        spurious_en = 1'b0;

  task automatic drive_mem();
    if (imem_req) begin
      if (mem_cnt >= mem_lat) begin
        imem_ack = 1'b1;
        mem_cnt  = 0;
      end else begin
        imem_ack = 1'b0;
        mem_cnt++;
      end
    end else begin
      imem_ack = spurious_en ? ($urandom_range(0, 7) == 0) : 1'b0;
      mem_cnt  = 0;
    end
    imem_rdata = rand_data ? $urandom : mem_word;
  endtask

  task automatic step();
    drive_mem();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int waits;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_imem_req",    {31'd0, imem_req},   32'd0);
    check("rst_imem_addr",   imem_addr,           32'h0);
    check("rst_inst_valid",  {31'd0, inst_valid}, 32'd0);
    check("rst_code",        Instruction_Code,    32'h0);
    check("rst_fault",       {31'd0, fault},      32'd0);
    check("rst_fetch_count", fetch_count,         32'd0);
    check("rst_state",       32'(state_dbg),      32'(BOOT));
    reset = 1'b0;
    @(negedge clock);
    check("boot_idle_req", {31'd0, imem_req}, 32'd0);
    step();
    check("boot_first_req",  {31'd0, imem_req}, 32'd1);
    check("boot_first_addr", imem_addr,         32'h0);

    // sequential fetch, single-cycle ack
    mem_lat = 0; mem_word = 32'h0000_0013; inst_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 40 && m.count < 4; i++) step();
    check("seq_count", fetch_count, 32'd4);
    check("seq_q_len", 32'(exp_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < exp_q.size(); i++)
      check("seq_pc", exp_q[i], 32'(i * 4));
    check("seq_next_addr", imem_addr, 32'h10);

    // back-pressure
    inst_ready = 1'b0; mem_word = 32'h0050_0093;
    for (int i = 0; i < 10 && !inst_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      check("bp_code",  Instruction_Code,  32'h0050_0093);
      check("bp_pc",    inst_pc,           32'h10);
      check("bp_req",   {31'd0, imem_req}, 32'd0);
      check("bp_count", fetch_count,       32'd4);
      step();
    end
    inst_ready = 1'b1;
    step();
    check("bp_release_count", fetch_count,         32'd5);
    check("bp_release_valid", {31'd0, inst_valid}, 32'd0);
    check("bp_release_addr",  imem_addr,           32'h14);

    // redirect in FETCH while the ack is 3 cycles late
    mem_lat = 3;
    check("rd_fetch_req", {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    waits = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_addr == 32'h100) break;
      check("drain_addr",  imem_addr,           32'h14);
      check("drain_valid", {31'd0, inst_valid}, 32'd0);
      step();
      waits++;
    end
    check("drain_cycles",   32'(waits),        32'd3);
    check("drain_new_addr", imem_addr,         32'h100);
    check("drain_new_req",  {31'd0, imem_req}, 32'd1);

    // redirect in HOLD with a same-cycle transfer
    mem_lat = 0; inst_ready = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) step();
    check("hold_pc",    inst_pc,     32'h100);
    check("hold_count", fetch_count, 32'd5);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("hold_rd_count", fetch_count,         32'd6);
    check("hold_rd_valid", {31'd0, inst_valid}, 32'd0);
    check("hold_rd_addr",  imem_addr,           32'h200);

    // misaligned redirect, with an ack in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("halt_fault", {31'd0, fault},      32'd1);
    check("halt_req",   {31'd0, imem_req},   32'd0);
    check("halt_pc",    inst_pc,             32'h100);
    spurious_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst_ready     = $urandom_range(0, 1);
      redirect_valid = (i == 3);
      redirect_pc    = 32'h40;
      step();
      check("halt_hold_req",   {31'd0, imem_req},   32'd0);
      check("halt_hold_valid", {31'd0, inst_valid}, 32'd0);
      check("halt_hold_fault", {31'd0, fault},      32'd1);
    end
    redirect_valid = 1'b0; spurious_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("halt_rst_fault", {31'd0, fault}, 32'd0);
    check("halt_rst_addr",  imem_addr,      32'h0);
    check("halt_rst_count", fetch_count,    32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("restart_idle", {31'd0, imem_req}, 32'd0);
    step();
    check("restart_req",  {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr,         32'h0);

    // random traffic
    rand_data = 1'b1; spurious_en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r              = $urandom_range(0, 299);
      inst_ready     = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(0, 3);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (r < 24) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'($urandom_range(0, 255)) << 2;
      end else if (r < 27) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
      end else if (r == 27) begin
        redirect_valid = 1'b1;
        redirect_pc    = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      end
      step();
      if (i % 200 == 199) pulse_reset();
    end
    redirect_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
